// File: rtl/dispatch_stage_pkg.sv
// Shared encodings for the dispatch stage: opClass values, tag prefixes,
// unit-select one-hots and small class-decoding helpers.
package dispatch_stage_pkg;

   typedef enum logic [3:0] {
      CLASS_LUI   = 4'd0,
      CLASS_AUIPC = 4'd1,
      CLASS_JAL   = 4'd2,
      CLASS_JALR  = 4'd3,
      CLASS_B     = 4'd4,
      CLASS_LD    = 4'd5,
      CLASS_ST    = 4'd6,
      CLASS_RI    = 4'd7,
      CLASS_RR    = 4'd8
   } op_class_e;

   // Full tag = {prefix, pool index}; the all-zero tag means "operand ready".
   localparam logic        PREFIX_ALU = 1'b0;
   localparam logic        PREFIX_LS  = 1'b1;
   localparam int unsigned TAG_FREE   = 0;
   localparam int unsigned NOP        = 0;

   localparam logic [2:0] UNIT_ALU = 3'b001;
   localparam logic [2:0] UNIT_BR  = 3'b010;
   localparam logic [2:0] UNIT_LS  = 3'b100;

   function automatic logic [2:0] unit_of(input logic [3:0] cls);
      if (cls == CLASS_B) return UNIT_BR;
      if (cls == CLASS_LD || cls == CLASS_ST) return UNIT_LS;
      return UNIT_ALU;
   endfunction

   function automatic logic needs_dest(input logic [3:0] cls, input logic rd_nonzero);
      return rd_nonzero && (cls != CLASS_B) && (cls != CLASS_ST);
   endfunction

   function automatic logic uses_rs1(input logic [3:0] cls);
      return !(cls == CLASS_LUI || cls == CLASS_AUIPC || cls == CLASS_JAL);
   endfunction

   function automatic logic uses_rs2(input logic [3:0] cls);
      return !(cls == CLASS_LUI || cls == CLASS_AUIPC || cls == CLASS_JAL ||
               cls == CLASS_JALR || cls == CLASS_LD || cls == CLASS_RI);
   endfunction

endpackage

// File: rtl/dispatch_stage_cdb_snoop.sv
// Resolves one operand against the CDB broadcasts: a pending tag that matches
// a valid channel takes that channel's data and becomes TAG_FREE.
module cdb_snoop
   import dispatch_stage_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 5,
   parameter int NUM_CDB = 2
) (
   input  logic [TAG_W-1:0]          tag_i,
   input  logic [DATA_W-1:0]         data_i,
   input  logic [NUM_CDB-1:0]        cdb_valid_i,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag_i,
   input  logic [NUM_CDB*DATA_W-1:0] cdb_data_i,
   output logic [TAG_W-1:0]          tag_o,
   output logic [DATA_W-1:0]         data_o
);

   always_comb begin
      // NOTE: outputs get their defaults first so every path assigns them and no latch is inferred.
      tag_o  = tag_i;
      data_o = data_i;
      // Walk from the top channel down so the lowest matching index wins.
      for (int i = NUM_CDB - 1; i >= 0; i--) begin
         if (tag_i != TAG_W'(TAG_FREE) && cdb_valid_i[i] &&
             cdb_tag_i[i*TAG_W +: TAG_W] == tag_i) begin
            tag_o  = TAG_W'(TAG_FREE);
            data_o = cdb_data_i[i*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/dispatch_stage.sv
// Registered dispatch stage: holds one decoded instruction, allocates and
// renames its destination tag, and snoops the CDB until the target accepts.
module dispatch_stage
   import dispatch_stage_pkg::*;
#(
   parameter  int DATA_W     = 32,
   parameter  int NAME_W     = 5,
   parameter  int TAG_ROOT_W = 4,
   parameter  int OP_W       = 6,
   parameter  int CLASS_W    = 4,
   parameter  int NUM_CDB    = 2,
   localparam int TAG_W      = TAG_ROOT_W + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CLASS_W-1:0]        in_class,
   input  logic [OP_W-1:0]           in_op,
   input  logic [DATA_W-1:0]         in_addr,
   input  logic [NAME_W-1:0]         in_rd,
   input  logic [DATA_W-1:0]         in_imm,
   input  logic [TAG_W-1:0]          in_tag1,
   input  logic [TAG_W-1:0]          in_tag2,
   input  logic [DATA_W-1:0]         in_data1,
   input  logic [DATA_W-1:0]         in_data2,
   input  logic                      alu_free_valid,
   input  logic                      ls_free_valid,
   input  logic [TAG_ROOT_W-1:0]     alu_free_tag,
   input  logic [TAG_ROOT_W-1:0]     ls_free_tag,
   output logic                      alu_take,
   output logic                      ls_take,
   output logic                      ren_en,
   output logic [NAME_W-1:0]         ren_name,
   output logic [TAG_W-1:0]          ren_tag,
   input  logic [NUM_CDB-1:0]        cdb_valid,
   input  logic [NUM_CDB*TAG_W-1:0]  cdb_tag,
   input  logic [NUM_CDB*DATA_W-1:0] cdb_data,
   output logic [2:0]                out_valid,
   input  logic [2:0]                out_ready,
   output logic [OP_W-1:0]           out_op,
   output logic [DATA_W-1:0]         out_addr,
   output logic [DATA_W-1:0]         out_imm,
   output logic [TAG_W-1:0]          out_tag1,
   output logic [TAG_W-1:0]          out_tag2,
   output logic [TAG_W-1:0]          out_tagw,
   output logic [DATA_W-1:0]         out_data1,
   output logic [DATA_W-1:0]         out_data2,
   output logic [NAME_W-1:0]         out_namew
);

   localparam logic [TAG_W-1:0] TAG_NONE = TAG_W'(TAG_FREE);

   logic [2:0]        valid_q, valid_d;
   logic [OP_W-1:0]   op_q, op_d;
   logic [DATA_W-1:0] addr_q, addr_d, imm_q, imm_d;
   logic [TAG_W-1:0]  tag1_q, tag1_d, tag2_q, tag2_d, tagw_q, tagw_d;
   logic [DATA_W-1:0] data1_q, data1_d, data2_q, data2_d;
   logic [NAME_W-1:0] namew_q, namew_d;

   logic [3:0]        cls;
   logic              held, fire_out, has_dest, use_ls_pool, tag_ok, accept;
   logic [TAG_W-1:0]  new_tagw;
   logic [TAG_W-1:0]  in_tag1_m, in_tag2_m, cap_tag1, cap_tag2, hold_tag1, hold_tag2;
   logic [DATA_W-1:0] in_data2_m, cap_data1, cap_data2, hold_data1, hold_data2;

   assign cls         = 4'(in_class);
   assign held        = |valid_q;
   assign fire_out    = |(valid_q & out_ready);
   assign has_dest    = needs_dest(cls, in_rd != '0);
   assign use_ls_pool = (cls == CLASS_LD);
   assign tag_ok      = !has_dest || (use_ls_pool ? ls_free_valid : alu_free_valid);
   assign in_ready    = (!held || fire_out) && !flush && tag_ok;
   assign accept      = in_valid && in_ready;

   assign new_tagw = !has_dest   ? TAG_NONE :
                     use_ls_pool ? {PREFIX_LS, ls_free_tag} : {PREFIX_ALU, alu_free_tag};

   assign alu_take = accept && has_dest && !use_ls_pool;
   assign ls_take  = accept && has_dest && use_ls_pool;
   assign ren_en   = accept && has_dest;
   assign ren_name = ren_en ? in_rd : '0;
   assign ren_tag  = ren_en ? new_tagw : TAG_NONE;

   // Classes without an rs1/rs2 read present their operand as already resolved.
   assign in_tag1_m  = uses_rs1(cls) ? in_tag1 : TAG_NONE;
   assign in_tag2_m  = uses_rs2(cls) ? in_tag2 : TAG_NONE;
   assign in_data2_m = uses_rs2(cls) ? in_data2 : '0;

   cdb_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_cap1 (
      .tag_i(in_tag1_m), .data_i(in_data1), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
      .cdb_data_i(cdb_data), .tag_o(cap_tag1), .data_o(cap_data1));
   cdb_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_cap2 (
      .tag_i(in_tag2_m), .data_i(in_data2_m), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
      .cdb_data_i(cdb_data), .tag_o(cap_tag2), .data_o(cap_data2));
   cdb_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_hold1 (
      .tag_i(tag1_q), .data_i(data1_q), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
      .cdb_data_i(cdb_data), .tag_o(hold_tag1), .data_o(hold_data1));
   cdb_snoop #(.DATA_W(DATA_W), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB)) u_hold2 (
      .tag_i(tag2_q), .data_i(data2_q), .cdb_valid_i(cdb_valid), .cdb_tag_i(cdb_tag),
      .cdb_data_i(cdb_data), .tag_o(hold_tag2), .data_o(hold_data2));

   always_comb begin
      valid_d = valid_q;
      op_d    = op_q;
      addr_d  = addr_q;
      imm_d   = imm_q;
      tag1_d  = hold_tag1;
      tag2_d  = hold_tag2;
      tagw_d  = tagw_q;
      data1_d = hold_data1;
      data2_d = hold_data2;
      namew_d = namew_q;
      if (flush) begin
         valid_d = '0;
         op_d    = OP_W'(NOP);
         addr_d  = '0;
         imm_d   = '0;
         tag1_d  = TAG_NONE;
         tag2_d  = TAG_NONE;
         tagw_d  = TAG_NONE;
         data1_d = '0;
         data2_d = '0;
         namew_d = '0;
      end else if (accept) begin
         // A fire on this same edge is simply overwritten by the new instruction.
         valid_d = unit_of(cls);
         op_d    = in_op;
         addr_d  = in_addr;
         imm_d   = in_imm;
         tag1_d  = cap_tag1;
         tag2_d  = cap_tag2;
         tagw_d  = new_tagw;
         data1_d = cap_data1;
         data2_d = cap_data2;
         namew_d = in_rd;
      end else if (fire_out) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= '0;
         op_q    <= OP_W'(NOP);
         addr_q  <= '0;
         imm_q   <= '0;
         tag1_q  <= TAG_NONE;
         tag2_q  <= TAG_NONE;
         tagw_q  <= TAG_NONE;
         data1_q <= '0;
         data2_q <= '0;
         namew_q <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         valid_q <= valid_d;
         op_q    <= op_d;
         addr_q  <= addr_d;
         imm_q   <= imm_d;
         tag1_q  <= tag1_d;
         tag2_q  <= tag2_d;
         tagw_q  <= tagw_d;
         data1_q <= data1_d;
         data2_q <= data2_d;
         namew_q <= namew_d;
      end
   end

   assign out_valid = valid_q;
   assign out_op    = op_q;
   assign out_addr  = addr_q;
   assign out_imm   = imm_q;
   assign out_tag1  = tag1_q;
   assign out_tag2  = tag2_q;
   assign out_tagw  = tagw_q;
   assign out_data1 = data1_q;
   assign out_data2 = data2_q;
   assign out_namew = namew_q;

endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
- Registered, back-pressured successor to the combinational dispatcher. Sits between decode/regfile read and the three issue targets: ALU RS, Branch RS and LS buffer.
- Captures one decoded instruction per cycle into a holding register and allocates a destination tag from the ALU or LS free-tag pool. It renames rd in the regfile at accept time.
- While the instruction waits for its target to accept it, the stage snoops NUM_CDB broadcast channels so that pending operands resolve in place.

Parameters:
DATA_W, 32, operand/immediate/address width
NAME_W, 5, architectural register name width
TAG_ROOT_W, 4, free-tag index width; full tag = 1 prefix bit + TAG_ROOT_W
OP_W, 6, opcode width
CLASS_W, 4, opClass width
NUM_CDB, 2, number of common-data-bus broadcast channels snooped

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  misprediction flush; kills held instruction
in_valid  in  1  decoder presents an instruction
in_ready  out  1  stage can accept this cycle
in_class  in  CLASS_W  opClass (LUI/AUIPC/JAL/JALR/B/LD/ST/RI/RR)
in_op  in  OP_W  opcode
in_addr  in  DATA_W  instruction address
in_rd  in  NAME_W  destination name
in_imm  in  DATA_W  immediate already selected by decoder for the class
in_tag1, in_tag2  in  TAG_W each  regfile tags of rs1/rs2
in_data1, in_data2  in  DATA_W each  regfile data of rs1/rs2
alu_free_valid, ls_free_valid  in  1 each  pool has a free entry
alu_free_tag, ls_free_tag  in  TAG_ROOT_W each  free index
alu_take, ls_take  out  1 each  one-cycle pulse consuming the offered index
ren_en  out  1  regfile rename strobe
ren_name  out  NAME_W  rd being renamed
ren_tag  out  TAG_W  new tag for rd
cdb_valid  in  NUM_CDB  broadcast valid per channel
cdb_tag  in  NUM_CDB*TAG_W  broadcast tags
cdb_data  in  NUM_CDB*DATA_W  broadcast data
out_valid  out  3  one-hot {ls, br, alu} request
out_ready  in  3  {ls, br, alu} target can accept
out_op, out_addr, out_imm  out  OP_W/DATA_W/DATA_W  held fields
out_tag1, out_tag2, out_tagw  out  TAG_W each  operand tags / destination tag
out_data1, out_data2  out  DATA_W each  operand data
out_namew  out  NAME_W  destination name

Behaviour:
- Reset (rst low, async):
  - holding register invalid; out_valid = 0.
  - All data outputs 0; all tags TAG_FREE; out_namew 0.
  - ren_en, alu_take, ls_take = 0.
- Fire conditions:
  - fire_out = |(out_valid & out_ready).
  - in_ready = (!held | fire_out) & !flush & tag_ok.
  - tag_ok = 1 when no destination is needed (B, ST, or in_rd == 0). Otherwise it is the pool's free_valid: LD uses the LS pool, all other classes use the ALU pool.
  - accept = in_valid & in_ready.
- On accept, registered into the holding register next edge:
  - Unit select: B → br, LD/ST → ls, else alu. The corresponding out_valid bit is set.
  - tagw = {prefix, pool tag} when a destination is needed, else TAG_FREE.
  - Same cycle, combinational: take pulse to the selected pool; ren_en/ren_name/ren_tag asserted.
- Operand masking per class, stored into the holding register:
  - tag2 = TAG_FREE, data2 = 0 for LUI/AUIPC/JAL/JALR/LD/RI.
  - tag1 = TAG_FREE for LUI/AUIPC/JAL, with data1 = in_data1 as presented.
- Capture bypass: if an incoming tag equals a valid cdb_tag this cycle, store that channel's data and TAG_FREE.
- Snoop while held: each cycle, each held tag ≠ TAG_FREE matching a valid channel takes that channel's data and becomes TAG_FREE.
  - This occurs even on the cycle of fire_out; the forwarded value is visible on the outputs from the next cycle.
  - The outputs themselves are driven from the register.
- Simultaneous fire_out & accept: the new instruction replaces the old one in the same edge (full throughput, 1/cycle).
- Latency: accept → out_valid is 1 cycle.
- out_valid holds stable with unchanged fields (except snooped operands) until out_ready.
- flush:
  - Clears the holding register next edge. No accept that cycle.
  - An out_valid/out_ready handshake on the flush cycle still counts; the target must drop it on flush itself.
- Multiple CDB matches on one tag: the lowest channel index wins (cannot occur legally).
- TAG_FREE is never a legal allocated tag.

Decomposition:
- Shared package (extend the existing defines):
  - CLASS_* encodings, LS/ALU tag prefixes, TAG_FREE, NOP.
  - Unit-select one-hot constants UNIT_ALU/UNIT_BR/UNIT_LS.
- One sub-module, cdb_snoop: given tag, data and the CDB buses, returns resolved tag/data. It is instantiated four times (two operands × capture/hold).

Test Plan:
- RR add, tags free, data 5/7, alu_free_tag 3 → next cycle out_valid = 001, data 5/7, tagw = {ALU,3}; ren_en pulse with rd = 4, alu_take pulse.
- LD with rs1 tag {ALU,2}, out_ready = 0 for 3 cycles, cdb channel 1 sends {ALU,2}/0x100 in cycle 2 → out_tag1 = TAG_FREE, out_data1 = 0x100 before ls fire; out_tagw = {LS,x}.
- ALU pool empty (alu_free_valid = 0) with RI presented → in_ready = 0, no take, no rename. ST presented in the same state → accepted, out_tagw = TAG_FREE.
- Back-to-back RR stream with out_ready = 1 → one fire per cycle, no bubbles. out_ready low for 1 cycle → exactly one in_ready low cycle.
- Incoming tag equals a live cdb broadcast on the accept cycle → held tag TAG_FREE and data equals broadcast.
- flush while held and stalled → out_valid = 0 next cycle. Async rst mid-stall → all outputs at reset values immediately.
